// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux16 channel scanner.
//   NUM_CH  : number of mux channels scanned per word
//   SEL_W   : width of the mux select
//   CNT_W   : width of the per-channel dwell counter
//   state_t : scanner FSM states
package mux_scan_pkg;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/mux16.sv
// 16:1 single-bit channel mux, instantiated beside the scanner.
//   w : channel inputs, w[k] is channel k
//   s : channel select
//   f : selected channel
module mux16 (
  input  logic [15:0] w,
  input  logic [3:0]  s,
  output logic        f
);

  assign f = w[s];

endmodule

// File: rtl/mux16_scanner.sv
// Steps the mux16 select through channels 0..15, samples the mux output after
// SETTLE+1 cycles of dwell per channel and presents the assembled 16-bit word.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a scan (only looked at in IDLE)
//   abort      : cancel scan / drop held word, highest priority
//   f_in       : mux16 output f
//   sel        : mux16 select s[3:0]
//   data       : captured word, data[k] sampled while sel == k
//   valid      : data complete and stable
//   ready      : consumer accepts data
//   busy       : FSM not in IDLE
//   dbg_state  : current FSM state
//
// Handshake: valid is high only in HOLD; the word transfers on the first
// rising edge where valid && ready. valid never drops without a transfer
// except on abort or reset, and data/sel are frozen while valid is high.
module mux16_scanner
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              f_in,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output state_t            dbg_state
);

  if (SETTLE > 15) begin : g_bad_settle
    $error("mux16_scanner: SETTLE must be in 0..15");
  end

  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [SEL_W-1:0]    r_sel;
  logic [NUM_CH-1:0]   r_cap;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [SEL_W-1:0]    w_sel_nxt;
  logic [NUM_CH-1:0]   w_cap_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_cap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      r_cap   <= w_cap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_cap_nxt   = r_cap;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_state_nxt = SCAN;
          w_cnt_nxt   = '0;
          w_sel_nxt   = '0;
          w_cap_nxt   = '0;
        end
      end
      SCAN: begin
        if (abort) begin
          // Partial capture is kept but never presented as valid.
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_sel_nxt   = '0;
        end else if (r_cnt == SETTLE_C) begin
          w_cap_nxt[r_sel] = f_in;
          w_cnt_nxt        = '0;
          if (r_sel == LAST_CH) begin
            // sel stays on the last channel; it only returns to 0 on exit.
            w_state_nxt = HOLD;
          end else begin
            w_sel_nxt = r_sel + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (abort || ready) begin
          w_state_nxt = IDLE;
          w_sel_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_sel_nxt   = '0;
      end
    endcase
  end

  assign sel       = r_sel;
  assign data      = r_cap;
  assign valid     = (r_state == HOLD);
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mux16_scanner.sv
module tb_mux16_scanner;
  import mux_scan_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // index 0: SETTLE = 0 instance, index 1: SETTLE = 3 instance
  logic        start_v [2];
  logic        abort_v [2];
  logic        ready_v [2];
  logic [15:0] w_v     [2];
  logic        f_v     [2];
  logic [3:0]  sel_v   [2];
  logic [15:0] data_v  [2];
  logic        valid_v [2];
  logic        busy_v  [2];
  state_t      st_v    [2];

  mux16 u_mux0 (.w(w_v[0]), .s(sel_v[0]), .f(f_v[0]));
  mux16_scanner #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .f_in(f_v[0]), .sel(sel_v[0]), .data(data_v[0]), .valid(valid_v[0]),
    .ready(ready_v[0]), .busy(busy_v[0]), .dbg_state(st_v[0])
  );

  mux16 u_mux1 (.w(w_v[1]), .s(sel_v[1]), .f(f_v[1]));
  mux16_scanner #(.SETTLE(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .f_in(f_v[1]), .sel(sel_v[1]), .data(data_v[1]), .valid(valid_v[1]),
    .ready(ready_v[1]), .busy(busy_v[1]), .dbg_state(st_v[1])
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int settle_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic check_reset_vals(input int d, input string tag);
    check({tag, "_sel"},   32'(sel_v[d]),   0);
    check({tag, "_data"},  32'(data_v[d]),  0);
    check({tag, "_valid"}, 32'(valid_v[d]), 0);
    check({tag, "_busy"},  32'(busy_v[d]),  0);
    check({tag, "_state"}, 32'(st_v[d]),    32'(IDLE));
  endtask

  // Full scan on instance d. The model samples w[k] as seen just before the
  // edge at which channel k has dwelt SETTLE+1 cycles. tog_ch >= 0 raises that
  // channel's input for only the first SETTLE cycles of its dwell.
  task automatic run_scan(input int d, input logic [15:0] w_pat,
                          input int rdy_delay, input int tog_ch);
    int s;
    int len;
    int dw0;
    logic [15:0] exp_w;
    s     = settle_of(d);
    len   = 16 * (s + 1);
    dw0   = (tog_ch >= 0) ? tog_ch * (s + 1) : 0;
    exp_w = '0;
    w_v[d]     = w_pat;
    ready_v[d] = 1'($urandom_range(0, 1));
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
    check("start_busy", 32'(busy_v[d]), 1);
    check("start_sel", 32'(sel_v[d]), 0);
    check("start_state", 32'(st_v[d]), 32'(SCAN));
    for (int t = 1; t <= len; t++) begin
      if (tog_ch >= 0)
        w_v[d][tog_ch] = ((t - 1) >= dw0) && ((t - 1) < dw0 + s);
      if (t % (s + 1) == 0)
        exp_w[t / (s + 1) - 1] = w_v[d][t / (s + 1) - 1];
      ready_v[d] = 1'($urandom_range(0, 1));   // ignored while scanning
      tick();
      if (t < len) begin
        check("scan_valid", 32'(valid_v[d]), 0);
        check("scan_sel", 32'(sel_v[d]), 32'(t / (s + 1)));
      end
    end
    exp_q.push_back(exp_w);
    check("hold_valid", 32'(valid_v[d]), 1);
    check("hold_sel", 32'(sel_v[d]), 15);
    check("hold_data", 32'(data_v[d]), 32'(exp_q[0]));
    ready_v[d] = (rdy_delay == 0);
    for (int i = 0; i < rdy_delay; i++) begin
      start_v[d] = 1'($urandom_range(0, 1));   // ignored in HOLD
      tick();
      check("bp_valid", 32'(valid_v[d]), 1);
      check("bp_data", 32'(data_v[d]), 32'(exp_q[0]));
      check("bp_sel", 32'(sel_v[d]), 15);
    end
    start_v[d] = 1'b0;
    ready_v[d] = 1'b1;
    tick();
    check("xfer_valid", 32'(valid_v[d]), 0);
    check("xfer_busy", 32'(busy_v[d]), 0);
    check("xfer_sel", 32'(sel_v[d]), 0);
    check("xfer_state", 32'(st_v[d]), 32'(IDLE));
    void'(exp_q.pop_front());
    ready_v[d] = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] w_tmp;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0; abort_v[d] = 1'b0; ready_v[d] = 1'b0; w_v[d] = '0;
    end
    rst_n = 1'b0;
    #12;
    check_reset_vals(0, "rst0");
    check_reset_vals(1, "rst1");
    rst_n = 1'b1;
    tick();

    // basic scan
    run_scan(0, 16'hA5C3, 0, -1);
    check("basic_word", 32'(data_v[0]), 32'h0000A5C3);

    // settle dwell: channel 7 high only for the first 3 cycles of its dwell
    run_scan(1, 16'hFF7F, 0, 7);
    check("settle_word", 32'(data_v[1]), 32'h0000FF7F);

    // backpressure
    run_scan(0, 16'($urandom), 10, -1);

    // abort at sel == 9
    w_tmp = 16'($urandom);
    w_v[0] = w_tmp;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    repeat (9) tick();
    check("abort_pre_sel", 32'(sel_v[0]), 9);
    abort_v[0] = 1'b1;
    tick();
    abort_v[0] = 1'b0;
    check("abort_sel", 32'(sel_v[0]), 0);
    check("abort_busy", 32'(busy_v[0]), 0);
    check("abort_valid", 32'(valid_v[0]), 0);
    check("abort_data", 32'(data_v[0]), 32'(w_tmp & 16'h01FF));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_idle_valid", 32'(valid_v[0]), 0);
    end
    run_scan(0, 16'($urandom), 2, -1);

    // abort in HOLD beats ready
    w_v[0] = 16'($urandom);
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    repeat (16) tick();
    check("habort_pre_valid", 32'(valid_v[0]), 1);
    abort_v[0] = 1'b1;
    ready_v[0] = 1'b1;
    tick();
    abort_v[0] = 1'b0;
    ready_v[0] = 1'b0;
    check("habort_valid", 32'(valid_v[0]), 0);
    check("habort_sel", 32'(sel_v[0]), 0);
    check("habort_busy", 32'(busy_v[0]), 0);

    // async reset mid-scan at sel == 5
    w_v[0] = 16'($urandom);
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    repeat (5) tick();
    check("arst_pre_sel", 32'(sel_v[0]), 5);
    #2 rst_n = 1'b0;
    #1 check_reset_vals(0, "arst_scan");
    #1 rst_n = 1'b1;
    tick();
    check("arst_scan_after", 32'(busy_v[0]), 0);

    // async reset in HOLD
    w_v[0] = 16'hFFFF;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    repeat (16) tick();
    check("arst_hold_pre", 32'(valid_v[0]), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals(0, "arst_hold");
    #1 rst_n = 1'b1;
    tick();
    run_scan(0, 16'($urandom), 1, -1);

    // back-to-back with start held high
    w_tmp = 16'($urandom);
    w_v[0] = w_tmp;
    start_v[0] = 1'b1;
    ready_v[0] = 1'b1;
    tick();
    for (int n = 0; n < 4; n++) begin
      exp_q.push_back(w_tmp);
      for (int t = 1; t <= 16; t++) begin
        tick();
        if (t < 16) check("b2b_valid_low", 32'(valid_v[0]), 0);
      end
      check("b2b_valid", 32'(valid_v[0]), 1);
      check("b2b_data", 32'(data_v[0]), 32'(exp_q[0]));
      tick();
      void'(exp_q.pop_front());
      check("b2b_gap_valid", 32'(valid_v[0]), 0);
      check("b2b_gap_busy", 32'(busy_v[0]), 0);
      check("b2b_gap_sel", 32'(sel_v[0]), 0);
      w_tmp = 16'($urandom);
      w_v[0] = w_tmp;
      if (n == 3) start_v[0] = 1'b0;
      tick();
      check("b2b_restart", 32'(busy_v[0]), (n == 3) ? 0 : 1);
    end
    ready_v[0] = 1'b0;

    // randomized scans on both instances
    for (int i = 0; i < 6; i++) begin
      run_scan(i % 2, 16'($urandom), $urandom_range(0, 4), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
